// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron accumulate interface: FP word layout,
// exception encodings and the driver state enumeration.
package neuron_pkg;

    // 14-bit word: {exc[1:0], sign, exp[4:0], frac[5:0]}
    localparam int FP_BITWIDTH = 12;
    localparam int FP_BW       = FP_BITWIDTH + 2 - 1;
    localparam int FP_W        = FP_BW + 1;
    localparam int FP_EXP_W    = 5;
    localparam int FP_FRAC_W   = 6;
    localparam int FP_EXP_BIAS = 15;

    localparam logic [FP_BW:0] FP_ZERO = '0;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } fp_exc_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } drv_state_t;

    // Exception field of an FP word.
    function automatic fp_exc_t fp_exc(input logic [FP_BW:0] w);
        return fp_exc_t'(w[FP_BW -: 2]);
    endfunction

endpackage

// File: rtl/neuron_driver.sv
// Sequencer for one dot-product pass through a neuron MAC: fetches
// weight/data pairs from two synchronous-read buffers, streams them into the
// neuron, then captures the final accumulator and offers it on a
// valid/ready result port. The driver performs no arithmetic.
module neuron_driver
    import neuron_pkg::*;
#(
    parameter int BITWIDTH = 12,
    parameter int BW       = BITWIDTH + 2 - 1,
    parameter int MAX_LEN  = 256,
    parameter int AW       = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          w_rd,
    output logic [AW-1:0] w_addr,
    input  logic [BW:0]   w_rdata,
    output logic          d_rd,
    output logic [AW-1:0] d_addr,
    input  logic [BW:0]   d_rdata,
    output logic          n_clear,
    output logic          n_en,
    output logic [BW:0]   n_weight,
    output logic [BW:0]   n_data,
    input  logic [BW:0]   n_accum,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [BW:0]   res_data
);

    localparam logic [AW:0] LEN_MAX = (AW + 1)'(MAX_LEN);

    drv_state_t    state_q;
    logic [AW:0]   len_q;
    logic [AW:0]   idx_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          rd_q;
    logic          issue_v_q;
    logic          n_clear_q;
    logic          res_valid_q;
    logic [BW:0]   res_data_q;

    // An out-of-range length would wrap the buffer address, so it is
    // limited to the buffer depth when latched.
    logic [AW:0]   len_d;
    logic          more_d;

    assign len_d  = (len > LEN_MAX) ? LEN_MAX : len;
    assign more_d = (idx_q < len_q);

    // Pass sequencer: state, read issue, clear pulse and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            issue_v_q   <= 1'b0;
            n_clear_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            // Single-cycle strobes default low; issue_v trails the read
            // strobe by the buffer's one-cycle read latency.
            n_clear_q <= 1'b0;
            rd_q      <= 1'b0;
            issue_v_q <= rd_q;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q     <= len_d;
                        busy_q    <= 1'b1;
                        n_clear_q <= 1'b1;
                        state_q   <= ST_CLEAR;
                        // The first read goes out alongside the clear.
                        if (len_d != '0) begin
                            rd_q   <= 1'b1;
                            addr_q <= '0;
                            idx_q  <= (AW + 1)'(1);
                        end else begin
                            idx_q  <= '0;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (more_d) begin
                        rd_q   <= 1'b1;
                        addr_q <= idx_q[AW-1:0];
                        idx_q  <= idx_q + 1'b1;
                    end
                    state_q <= (len_q != '0) ? ST_RUN : ST_WAIT;
                end

                ST_RUN: begin
                    if (more_d) begin
                        rd_q   <= 1'b1;
                        addr_q <= idx_q[AW-1:0];
                        idx_q  <= idx_q + 1'b1;
                    end
                    // Current cycle carries the last term when data is being
                    // presented and no further read is in flight.
                    if (issue_v_q && !rd_q) begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Neuron accum is registered, so the last term is
                    // reflected here, one cycle after the final n_en.
                    res_data_q  <= n_accum;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign w_rd      = rd_q;
    assign d_rd      = rd_q;
    assign w_addr    = addr_q;
    assign d_addr    = addr_q;
    assign n_clear   = n_clear_q;
    assign n_en      = issue_v_q;
    // Buffer words pass straight through only while they are valid terms.
    assign n_weight  = issue_v_q ? w_rdata : '0;
    assign n_data    = issue_v_q ? d_rdata : '0;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_neuron_driver.sv
`timescale 1ns/1ps
module tb_neuron_driver;
    import neuron_pkg::*;

    localparam int BITWIDTH = 12;
    localparam int BW       = BITWIDTH + 2 - 1;
    localparam int MAX_LEN  = 256;
    localparam int AW       = 8;

    localparam logic [BW:0] FP_ONE   = 14'b01_0_01111_000000;
    localparam logic [BW:0] FP_TWO   = 14'b01_0_10000_000000;
    localparam logic [BW:0] FP_THREE = 14'b01_0_10000_100000;
    localparam logic [BW:0] FP_HALF  = 14'b01_0_01110_000000;
    localparam logic [BW:0] FP_5     = 14'b01_0_10001_010000;
    localparam logic [BW:0] FP_14    = 14'b01_0_10010_110000;
    localparam logic [BW:0] FP_128   = 14'b01_0_10110_000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          nrst;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          w_rd, d_rd;
    logic [AW-1:0] w_addr, d_addr;
    logic [BW:0]   w_rdata, d_rdata;
    logic          n_clear, n_en;
    logic [BW:0]   n_weight, n_data, n_accum;
    logic          res_valid, res_ready;
    logic [BW:0]   res_data;

    always #5 clk = ~clk;

    neuron_driver #(
        .BITWIDTH(BITWIDTH), .BW(BW), .MAX_LEN(MAX_LEN), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
        .d_rd(d_rd), .d_addr(d_addr), .d_rdata(d_rdata),
        .n_clear(n_clear), .n_en(n_en), .n_weight(n_weight), .n_data(n_data),
        .n_accum(n_accum), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    // ---------------- FP helpers (value domain) ----------------
    function automatic real fp_dec(input logic [BW:0] v);
        real m;
        int  e;
        if (v[BW -: 2] != EXC_NORMAL) return 0.0;
        m = 1.0 + real'(int'(v[5:0])) / 64.0;
        e = int'(v[10:6]) - FP_EXP_BIAS;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return v[11] ? -m : m;
    endfunction

    function automatic logic [BW:0] fp_enc(input real x);
        real  a;
        int   e;
        int   f;
        logic s;
        if (x == 0.0) return FP_ZERO;
        s = (x < 0.0);
        a = s ? -x : x;
        e = FP_EXP_BIAS;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        if (e < 1) return FP_ZERO;
        if (e > 30) return {EXC_INF, s, 11'b0};
        f = $rtoi((a - 1.0) * 64.0);
        return {EXC_NORMAL, s, e[4:0], f[5:0]};
    endfunction

    // ---------------- buffer models ----------------
    logic [BW:0] wbuf [MAX_LEN];
    logic [BW:0] dbuf [MAX_LEN];

    always @(posedge clk) begin
        if (w_rd) w_rdata <= wbuf[w_addr];
        if (d_rd) d_rdata <= dbuf[d_addr];
    end

    // ---------------- neuron model (own reset, registered accum) ----------------
    real acc_r = 0.0;
    always @(posedge clk) begin
        if (!nrst)        acc_r <= 0.0;
        else if (n_clear) acc_r <= 0.0;
        else if (n_en)    acc_r <= acc_r + fp_dec(n_weight) * fp_dec(n_data);
    end
    assign n_accum = fp_enc(acc_r);

    // ---------------- reference: dot product of buffer contents ----------------
    function automatic logic [BW:0] ref_dot(input int L);
        real s;
        s = 0.0;
        for (int k = 0; k < L; k++) s = s + fp_dec(wbuf[k]) * fp_dec(dbuf[k]);
        return fp_enc(s);
    endfunction

    function automatic logic [BW:0] rand_fp();
        logic [4:0] e;
        if ($urandom_range(0, 7) == 0) return FP_ZERO;
        e = 5'($urandom_range(13, 17));
        return {EXC_NORMAL, 1'($urandom_range(0, 1)), e, 6'($urandom_range(0, 63))};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [BW:0] val;
        int          nterms;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int outs_ones();
        return $countones({busy, w_rd, d_rd, w_addr, d_addr, n_clear, n_en,
                           n_weight, n_data, res_valid, res_data});
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        int          en_cnt, rd_cnt, clr_cnt, t_clr, t_valid, seq_err;
        logic        prev_valid, prev_hs;
        logic [BW:0] prev_data;
        exp_t        e;
        en_cnt = 0; rd_cnt = 0; clr_cnt = 0; t_clr = -1; t_valid = -1; seq_err = 0;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                en_cnt = 0; rd_cnt = 0; clr_cnt = 0; t_clr = -1; t_valid = -1; seq_err = 0;
                prev_valid = 1'b0; prev_hs = 1'b0;
            end else begin
                if (exp_q.size() == 0)
                    check("idle_activity", $countones({n_clear, w_rd, d_rd, n_en, res_valid}), 0);
                if (n_clear && n_en) seq_err++;
                if (n_clear) begin clr_cnt++; t_clr = cyc; end
                if (w_rd || d_rd) begin
                    if (!(w_rd && d_rd) || int'(w_addr) != rd_cnt || int'(d_addr) != rd_cnt)
                        seq_err++;
                    if (exp_q.size() > 0 && cyc != exp_q[0].t0 + 1 + rd_cnt) seq_err++;
                    rd_cnt++;
                end
                if (n_en) begin
                    if (en_cnt >= MAX_LEN) seq_err++;
                    else if (n_weight !== wbuf[en_cnt] || n_data !== dbuf[en_cnt]) seq_err++;
                    if (exp_q.size() > 0 && cyc != exp_q[0].t0 + 2 + en_cnt) seq_err++;
                    en_cnt++;
                end else if (n_weight != '0 || n_data != '0) begin
                    seq_err++;
                end
                if (res_valid && !prev_valid) t_valid = cyc;
                if (res_valid && prev_valid && !prev_hs && res_data != prev_data) seq_err++;
                if (res_valid && !busy) seq_err++;
                prev_hs = res_valid && res_ready;
                if (res_valid && res_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("result",      res_data, e.val);
                    check("en_count",    en_cnt, e.nterms);
                    check("rd_count",    rd_cnt, e.nterms);
                    check("clear_count", clr_cnt, 1);
                    check("clear_time",  t_clr - e.t0, 1);
                    check("latency",     t_valid - e.t0, e.nterms + 3);
                    check("protocol",    seq_err, 0);
                    en_cnt = 0; rd_cnt = 0; clr_cnt = 0; t_clr = -1; t_valid = -1; seq_err = 0;
                end
                prev_valid = res_valid;
                prev_data  = res_data;
            end
        end
    end

    // ---------------- stimulus tasks (entered #1 after a rising edge) ----------------
    task automatic launch(input int L, input logic [BW:0] expv);
        exp_t e;
        e.val = expv; e.nterms = L; e.t0 = cyc;
        start = 1'b1;
        len   = L[AW:0];
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_pass(input int L, input int hold, input bit stray, input bit b2b);
        int waited;
        bit seen;
        waited = 0; seen = 1'b0;
        while (!seen && waited < L + 10) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
            else waited++;
        end
        if (!seen) begin
            check("valid_timeout", res_valid, 1);
            exp_q.delete();
            @(posedge clk); #1; rst = 1'b0;
            @(posedge clk); #1; rst = 1'b1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            start = stray && (i == 1);
            len   = 9'd7;
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        start     = b2b;
        len       = 9'd5;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
        if (!b2b) begin
            @(negedge clk);
            check("idle_after_handshake", busy, 0);
            @(posedge clk); #1;
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        int          L;
        logic [BW:0] expv;
        rst = 1'b0; nrst = 1'b0; start = 1'b0; len = '0; res_ready = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin wbuf[i] = FP_ZERO; dbuf[i] = FP_ZERO; end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_ones(), 0);
        rst = 1'b1; nrst = 1'b1;
        @(posedge clk); #1;

        // len=3, {1,2,3}.{1,2,3} = 14
        wbuf[0] = FP_ONE; wbuf[1] = FP_TWO; wbuf[2] = FP_THREE;
        dbuf[0] = FP_ONE; dbuf[1] = FP_TWO; dbuf[2] = FP_THREE;
        launch(3, FP_14);
        finish_pass(3, 0, 1'b0, 1'b0);

        // len=0: clear only, zero result
        launch(0, FP_ZERO);
        finish_pass(0, 1, 1'b0, 1'b0);

        // backpressure with a stray start while holding
        wbuf[0] = FP_ONE; wbuf[1] = FP_TWO;
        dbuf[0] = FP_ONE; dbuf[1] = FP_TWO;
        launch(2, FP_5);
        finish_pass(2, 5, 1'b1, 1'b0);

        // full-length pass: 256 * (1.0 * 0.5) = 128
        for (int i = 0; i < MAX_LEN; i++) begin wbuf[i] = FP_ONE; dbuf[i] = FP_HALF; end
        launch(MAX_LEN, FP_128);
        finish_pass(MAX_LEN, 0, 1'b0, 1'b0);

        // reset during the 2nd n_en of a len=4 pass
        for (int i = 0; i < 4; i++) begin wbuf[i] = FP_THREE; dbuf[i] = FP_TWO; end
        launch(4, FP_ZERO);           // cycle t; now in t+1
        @(posedge clk); #1;           // t+2: first n_en
        @(posedge clk); #1;           // t+3: second n_en
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;           // t+4
        check("midpass_reset_outputs", outs_ones(), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        wbuf[0] = FP_ONE; wbuf[1] = FP_TWO;
        dbuf[0] = FP_ONE; dbuf[1] = FP_TWO;
        launch(2, FP_5);
        finish_pass(2, 0, 1'b0, 1'b0);

        // back-to-back: start in handshake cycle ignored, next cycle accepted
        wbuf[0] = FP_THREE; wbuf[1] = FP_HALF;
        dbuf[0] = FP_TWO;   dbuf[1] = FP_THREE;
        launch(2, ref_dot(2));
        finish_pass(2, 2, 1'b0, 1'b1);
        wbuf[0] = FP_ONE; wbuf[1] = FP_TWO; wbuf[2] = FP_THREE;
        dbuf[0] = FP_ONE; dbuf[1] = FP_TWO; dbuf[2] = FP_THREE;
        launch(3, FP_14);
        finish_pass(3, 0, 1'b0, 1'b0);

        // randomized passes
        for (int p = 0; p < 24; p++) begin
            L = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 40) : $urandom_range(0, 12);
            for (int k = 0; k < L; k++) begin wbuf[k] = rand_fp(); dbuf[k] = rand_fp(); end
            expv = ref_dot(L);
            launch(L, expv);
            finish_pass(L, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                        (p != 23) && ($urandom_range(0, 2) == 0));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
